// File: rtl/uart_full_duplex_param.sv
// Parametrised full-duplex UART: registered TX serializer and mid-bit sampled RX
// with parity/framing error flags and an internal loopback path.
module uart_full_duplex_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 loopback,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 txd,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);
    localparam int CW = $clog2(2 * CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_ZERO  = {IW{1'b0}};
    localparam logic [IW-1:0] IDX_ONE   = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic          PAR_EN    = (PARITY_EN != 0);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_PARITY = 3'd3;
    localparam logic [2:0] RX_STOP   = 3'd4;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (^d) ^ PAR_ODD;
    endfunction

    logic [2:0]           tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [IW-1:0]        tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 ser_q, ser_d;
    logic                 txd_q, txd_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 tx_done_q, tx_done_d;

    logic                 sync1_q, sync2_q, line_prev_q;
    logic                 line_s, fall_s;
    logic [2:0]           rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [IW-1:0]        rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_bit_q, rx_par_bit_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ferr_q, rx_ferr_d;

    // TX next-state: ser_d is the serializer bit, the pin copy is forced high in loopback.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_data_d  = tx_data_q;
        ser_d      = ser_q;
        tx_busy_d  = tx_busy_q;
        tx_done_d  = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_start) begin
                    tx_state_d = TX_START;
                    tx_data_d  = tx_data;
                    tx_cnt_d   = CNT_ZERO;
                    tx_idx_d   = IDX_ZERO;
                    ser_d      = 1'b0;
                    tx_busy_d  = 1'b1;
                end else begin
                    ser_d      = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = CNT_ZERO;
                    ser_d      = tx_data_q[tx_idx_q];
                end else begin
                    tx_cnt_d   = tx_cnt_q + CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = CNT_ZERO;
                    if (tx_idx_q == IDX_LAST) begin
                        if (PAR_EN) begin
                            tx_state_d = TX_PARITY;
                            ser_d      = parity_of(tx_data_q);
                        end else begin
                            tx_state_d = TX_STOP;
                            ser_d      = 1'b1;
                        end
                    end else begin
                        tx_idx_d = tx_idx_q + IDX_ONE;
                        ser_d    = tx_data_q[tx_idx_q + IDX_ONE];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            TX_PARITY: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = TX_STOP;
                    tx_cnt_d   = CNT_ZERO;
                    ser_d      = 1'b1;
                end else begin
                    tx_cnt_d   = tx_cnt_q + CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == STOP_LAST) begin
                    tx_state_d = TX_IDLE;
                    tx_cnt_d   = CNT_ZERO;
                    tx_busy_d  = 1'b0;
                    tx_done_d  = 1'b1;
                end else begin
                    tx_cnt_d   = tx_cnt_q + CNT_ONE;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_cnt_d   = CNT_ZERO;
                ser_d      = 1'b1;
                tx_busy_d  = 1'b0;
            end
        endcase
        txd_d = loopback ? 1'b1 : ser_d;
    end

    // TX state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= CNT_ZERO;
            tx_idx_q   <= IDX_ZERO;
            tx_data_q  <= {DATA_BITS{1'b0}};
            ser_q      <= 1'b1;
            txd_q      <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_data_q  <= tx_data_d;
            ser_q      <= ser_d;
            txd_q      <= txd_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    // Loopback taps the serializer bit directly, skipping the synchronizer.
    assign line_s = loopback ? ser_q : sync2_q;
    assign fall_s = line_prev_q & ~line_s;

    // Input synchronizer and previous-line register for start-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            line_prev_q <= 1'b1;
        end else begin
            sync1_q     <= rxd;
            sync2_q     <= sync1_q;
            line_prev_q <= line_s;
        end
    end

    // RX next-state: one sample per bit at mid-bit, results published with rx_valid.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_idx_d     = rx_idx_q;
        rx_shift_d   = rx_shift_q;
        rx_par_bit_d = rx_par_bit_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rx_perr_d    = rx_perr_q;
        rx_ferr_d    = rx_ferr_q;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = CNT_ZERO;
                if (fall_s) begin
                    rx_state_d = RX_START;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = CNT_ZERO;
                    rx_idx_d = IDX_ZERO;
                    if (line_s) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_shift_d = {line_s, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_idx_q == IDX_LAST) begin
                        rx_state_d = PAR_EN ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + IDX_ONE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_PARITY: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d     = CNT_ZERO;
                    rx_par_bit_d = line_s;
                    rx_state_d   = RX_STOP;
                end else begin
                    rx_cnt_d     = rx_cnt_q + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_state_d = RX_IDLE;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_shift_q;
                    rx_ferr_d  = ~line_s;
                    if (PAR_EN) begin
                        rx_perr_d = parity_of(rx_shift_q) ^ rx_par_bit_q;
                    end else begin
                        rx_perr_d = 1'b0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
                rx_cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // RX state and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= CNT_ZERO;
            rx_idx_q     <= IDX_ZERO;
            rx_shift_q   <= {DATA_BITS{1'b0}};
            rx_par_bit_q <= 1'b0;
            rx_data_q    <= {DATA_BITS{1'b0}};
            rx_valid_q   <= 1'b0;
            rx_perr_q    <= 1'b0;
            rx_ferr_q    <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_idx_q     <= rx_idx_d;
            rx_shift_q   <= rx_shift_d;
            rx_par_bit_q <= rx_par_bit_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_perr_q    <= rx_perr_d;
            rx_ferr_q    <= rx_ferr_d;
        end
    end

    assign txd           = txd_q;
    assign tx_busy       = tx_busy_q;
    assign tx_done       = tx_done_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_full_duplex_param.sv
// Bench for uart_full_duplex_param: timestamp-based frame model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_full_duplex_param;
    localparam int DB  = 8;
    localparam int CPB = 4;
    localparam int PE  = 1;
    localparam int PO  = 0;
    localparam int SB  = 1;
    localparam int FB  = 1 + DB + PE + SB;
    localparam int N   = FB * CPB;
    localparam int H   = CPB / 2;
    localparam bit PE_B = (PE != 0);
    localparam bit PO_B = (PO != 0);

    logic          clk, rst, loopback, tx_start, rxd;
    logic [DB-1:0] tx_data;
    logic          tx_busy, tx_done, txd, rx_valid, rx_parity_err, rx_frame_err;
    logic [DB-1:0] rx_data;

    int checks = 0;
    int errors = 0;
    int lb_low = 0;
    logic [DB+1:0] rxq[$];

    uart_full_duplex_param #(
        .DATA_BITS(DB), .CLKS_PER_BIT(CPB), .PARITY_EN(PE), .PARITY_ODD(PO), .STOP_BITS(SB)
    ) dut (
        .clk(clk), .rst(rst), .loopback(loopback), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .txd(txd), .rxd(rxd), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Serial line bit idx of a frame; pflip corrupts parity, stopv is the first stop bit.
    function automatic logic frame_bit(input logic [DB-1:0] d, input logic pflip,
                                       input logic stopv, input int idx);
        if (idx == 0) return 1'b0;
        else if (idx <= DB) return d[idx-1];
        else if (PE_B && idx == DB + 1) return (^d) ^ PO_B ^ pflip;
        else if (idx == 1 + DB + PE) return stopv;
        else return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) if (rx_valid) rxq.push_back({rx_parity_err, rx_frame_err, rx_data});
    always @(negedge clk) if (loopback && !txd) lb_low <= lb_low + 1;

    // Reference model: compare outputs, then predict the next edge from the current inputs.
    int cyc = 0;
    bit m_tx_act, m_rx_act;
    int m_tx_t0, m_rx_t0, k, j;
    logic [DB-1:0] m_tx_dat, m_rx_dat;
    logic m_ser, m_s1, m_s2, m_prev, m_pbit, line;
    logic e_txd, e_busy, e_done, e_valid, e_perr, e_ferr;
    logic [DB-1:0] e_data;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                e_txd = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_valid = 1'b0;
                e_data = '0; e_perr = 1'b0; e_ferr = 1'b0;
            end
            chk("txd", 32'(txd), 32'(e_txd));
            chk("tx_busy", 32'(tx_busy), 32'(e_busy));
            chk("tx_done", 32'(tx_done), 32'(e_done));
            chk("rx_valid", 32'(rx_valid), 32'(e_valid));
            chk("rx_data", 32'(rx_data), 32'(e_data));
            chk("rx_parity_err", 32'(rx_parity_err), 32'(e_perr));
            chk("rx_frame_err", 32'(rx_frame_err), 32'(e_ferr));
            if (!rst) begin
                m_tx_act = 1'b0; m_rx_act = 1'b0; m_ser = 1'b1;
                m_s1 = 1'b1; m_s2 = 1'b1; m_prev = 1'b1;
            end else begin
                line = loopback ? m_ser : m_s2;
                m_s2 = m_s1;
                m_s1 = rxd;
                e_done = 1'b0;
                if (m_tx_act) begin
                    k = cyc - m_tx_t0;
                    if (k == N) begin
                        m_tx_act = 1'b0; m_ser = 1'b1; e_busy = 1'b0; e_done = 1'b1;
                    end else begin
                        m_ser = frame_bit(m_tx_dat, 1'b0, 1'b1, k / CPB);
                    end
                end else if (tx_start) begin
                    m_tx_act = 1'b1; m_tx_t0 = cyc; m_tx_dat = tx_data; m_ser = 1'b0; e_busy = 1'b1;
                end else begin
                    m_ser = 1'b1;
                end
                e_txd = loopback ? 1'b1 : m_ser;
                e_valid = 1'b0;
                if (!m_rx_act) begin
                    if (m_prev && !line) begin m_rx_act = 1'b1; m_rx_t0 = cyc; end
                end else begin
                    k = cyc - m_rx_t0;
                    if (k >= H && (k - H) % CPB == 0) begin
                        j = (k - H) / CPB;
                        if (j == 0) begin
                            if (line) m_rx_act = 1'b0;
                        end else if (j <= DB) begin
                            m_rx_dat[j-1] = line;
                        end else if (PE_B && j == DB + 1) begin
                            m_pbit = line;
                        end else begin
                            e_valid = 1'b1; e_data = m_rx_dat; e_ferr = ~line;
                            e_perr = PE_B ? ((^m_rx_dat) ^ PO_B ^ m_pbit) : 1'b0;
                            m_rx_act = 1'b0;
                        end
                    end
                end
                m_prev = line;
            end
            cyc++;
        end
    end

    task automatic drive_rx(input logic [DB-1:0] d, input logic pflip, input logic stopv, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            rxd = frame_bit(d, pflip, stopv, c / CPB);
            tick();
        end
    endtask

    task automatic wait_q(input int n, input int limit, input string nm);
        int i;
        i = 0;
        while (rxq.size() < n && i < limit) begin tick(); i++; end
        chk(nm, 32'(rxq.size() >= n), 32'd1);
    endtask

    task automatic pop_chk(input string nm, input logic [DB-1:0] d, input logic pe, input logic fe);
        logic [DB+1:0] e;
        chk({nm, "_present"}, 32'(rxq.size() > 0), 32'd1);
        if (rxq.size() > 0) begin
            e = rxq.pop_front();
            chk({nm, "_data"}, 32'(e[DB-1:0]), 32'(d));
            chk({nm, "_perr"}, 32'(e[DB+1]), 32'(pe));
            chk({nm, "_ferr"}, 32'(e[DB]), 32'(fe));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:10] seq;
        logic [DB-1:0] d;
        logic pf, sv;
        int busy_n, done_n, done_at, lb_base;

        rst = 1'b1; loopback = 1'b0; tx_start = 1'b0; tx_data = '0; rxd = 1'b1;
        #2 rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;

        // 1: idle after reset
        repeat (100) tick();
        chk("idle_txd", 32'(txd), 32'd1);
        chk("idle_busy", 32'(tx_busy), 32'd0);
        chk("idle_done", 32'(tx_done), 32'd0);
        chk("idle_valid", 32'(rxq.size()), 32'd0);
        chk("idle_perr", 32'(rx_parity_err), 32'd0);
        chk("idle_ferr", 32'(rx_frame_err), 32'd0);
        chk("model_par_c1", 32'(frame_bit(8'hC1, 1'b0, 1'b1, 9)), 32'd1);
        chk("model_par_81", 32'(frame_bit(8'h81, 1'b0, 1'b1, 9)), 32'd0);

        // 2: TX framing of 0xC1, second start mid-frame ignored
        seq = 11'b0_1000_0011_1_1;
        tx_data = 8'hC1; tx_start = 1'b1;
        tick();
        tx_start = 1'b0; tx_data = 8'h5A;
        busy_n = 0; done_n = 0; done_at = -1;
        for (int c = 0; c <= 46; c++) begin
            if (c < 44) chk("tx_seq", 32'(txd), 32'(seq[c / 4]));
            busy_n += int'(tx_busy);
            if (tx_done) begin done_n++; done_at = c; end
            tx_start = (c == 10);
            tick();
        end
        tx_start = 1'b0;
        chk("tx_busy_cycles", 32'(busy_n), 32'd44);
        chk("tx_done_count", 32'(done_n), 32'd1);
        chk("tx_done_at", 32'(done_at), 32'd44);

        // 3: loopback back-to-back 0x81 then 0x3C
        repeat (5) tick();
        rxq.delete();
        lb_base = lb_low;
        loopback = 1'b1;
        tx_data = 8'h81; tx_start = 1'b1;
        tick();
        tx_data = 8'h3C;
        repeat (N + 1) tick();
        tx_start = 1'b0;
        wait_q(2, 3 * N, "lb_wait");
        pop_chk("lb0", 8'h81, 1'b0, 1'b0);
        pop_chk("lb1", 8'h3C, 1'b0, 1'b0);
        chk("lb_txd_high", 32'(lb_low - lb_base), 32'd0);
        loopback = 1'b0;
        repeat (5) tick();

        // 4: parity error
        rxq.delete();
        drive_rx(8'h81, 1'b1, 1'b1, N);
        rxd = 1'b1;
        wait_q(1, 40, "perr_wait");
        pop_chk("perr", 8'h81, 1'b1, 1'b0);

        // 5: frame error, line held low, then a one-cycle glitch
        repeat (5) tick();
        rxq.delete();
        drive_rx(8'h55, 1'b0, 1'b0, N);
        rxd = 1'b0;
        repeat (2 * CPB) tick();
        rxd = 1'b1;
        repeat (10) tick();
        pop_chk("ferr", 8'h55, 1'b0, 1'b1);
        rxd = 1'b0;
        tick();
        rxd = 1'b1;
        repeat (40) tick();
        chk("glitch_no_valid", 32'(rxq.size()), 32'd0);
        chk("glitch_ferr_held", 32'(rx_frame_err), 32'd1);
        chk("glitch_data_held", 32'(rx_data), 32'h55);

        // 6: reset during data bits of a TX and an RX frame
        rxq.delete();
        tx_data = 8'hE7; tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        drive_rx(8'h3A, 1'b0, 1'b1, 20);
        rst = 1'b0;
        #1;
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        rxd = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        repeat (N) tick();
        chk("rst_no_valid", 32'(rxq.size()), 32'd0);
        loopback = 1'b1;
        tx_data = 8'hA5; tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        wait_q(1, 3 * N, "post_rst_wait");
        pop_chk("post_rst", 8'hA5, 1'b0, 1'b0);
        loopback = 1'b0;
        repeat (5) tick();

        // Randomized traffic, checked by the model every cycle
        for (int it = 0; it < 24; it++) begin
            loopback = 1'($urandom_range(0, 1));
            if (loopback) begin
                for (int c = 0; c < 3 * N; c++) begin
                    tx_start = ($urandom_range(0, 3) == 0);
                    tx_data = DB'($urandom);
                    tick();
                end
            end else begin
                d = DB'($urandom);
                pf = ($urandom_range(0, 3) == 0);
                sv = ($urandom_range(0, 3) != 0);
                for (int c = 0; c < N; c++) begin
                    rxd = frame_bit(d, pf, sv, c / CPB);
                    tx_start = ($urandom_range(0, 7) == 0);
                    tx_data = DB'($urandom);
                    tick();
                end
                rxd = 1'b1;
                tx_start = 1'b0;
                repeat (4) tick();
                if ($urandom_range(0, 2) == 0) begin
                    rxd = 1'b0;
                    tick();
                    rxd = 1'b1;
                end
            end
            tx_start = 1'b0;
            rxd = 1'b1;
            repeat (N + 8) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_full_duplex_param.md
Name: uart_full_duplex_param

Overview:
Parametrised full-duplex UART with one independent transmitter and one independent receiver sharing a clock. Generalises the fixed 8-bit full-duplex UART with:
- configurable data width, baud divisor, parity mode and stop-bit count;
- mid-bit sampled RX with false-start rejection;
- parity and framing error reporting;
- internal loopback mode.

It sits between the system logic and the serial pins (txd/rxd).

Parameters:
DATA_BITS, 8, payload bits per frame (5..9), sent LSB first
CLKS_PER_BIT, 16, clk cycles per serial bit (>=4, even)
PARITY_EN, 1, 1 = parity bit follows the data, 0 = no parity bit
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
STOP_BITS, 1, number of stop bits transmitted (1 or 2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
loopback  in  1  1 = RX input internally taken from the TX serializer; txd held high
tx_start  in  1  request to send tx_data; sampled only in TX IDLE
tx_data  in  DATA_BITS  payload, captured on the accepted tx_start
tx_busy  out  1  TX frame in progress
tx_done  out  1  one-cycle pulse at end of frame
txd  out  1  serial output, idle high
rxd  in  1  serial input, asynchronous
rx_data  out  DATA_BITS  last received payload, held until the next frame completes
rx_valid  out  1  one-cycle pulse when a frame completes
rx_parity_err  out  1  parity mismatch on the last frame; updated with rx_valid
rx_frame_err  out  1  first stop bit sampled low; updated with rx_valid

Behaviour:
Clock, reset and frame length:
- One clock: clk. Reset: rst, asynchronous, active-low.
- On reset, both FSMs go to IDLE and all counters clear.
- Reset values: txd=1, tx_busy=0, tx_done=0, rx_data=0, rx_valid=0, rx_parity_err=0, rx_frame_err=0.
- A reset mid-frame aborts the frame immediately, with no partial rx_valid.
- Frame length N = (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Parity bit = XOR of the data bits, XOR PARITY_ODD.

TX FSM (IDLE -> START -> DATA -> PARITY -> STOP -> IDLE):
- IDLE: on the edge where tx_start=1, latch tx_data, set tx_busy=1, go to START.
- txd is registered. It is 0 from that edge for CLKS_PER_BIT cycles.
- A bit counter (0..CLKS_PER_BIT-1) advances the bit. An index counter walks the data bits, LSB first.
- PARITY is skipped when PARITY_EN=0.
- STOP drives txd=1 for STOP_BITS*CLKS_PER_BIT cycles.
- On the edge that ends STOP (N cycles after acceptance): tx_busy=0, tx_done=1 for one cycle, state returns to IDLE.
- A new tx_start may be accepted on the following edge, giving back-to-back frames with no idle gap.
- tx_start while tx_busy=1 is ignored; tx_data changes after acceptance have no effect.
- loopback=1: the pin txd is forced to 1; the serializer runs unchanged and its bit is fed to RX.

RX synchronisation and sampling:
- rxd passes through a 2-flop synchronizer (bypassed in loopback mode).
- IDLE: a synchronized falling edge enters START and loads the counter.
- START: at CLKS_PER_BIT/2 cycles the line is sampled.
  - If high: false start, return to IDLE, no flags change.
  - If low: proceed.
- Each following bit is sampled once, CLKS_PER_BIT cycles after the previous sample, i.e. at mid-bit.
- Sample order: data bits (LSB first, shifted into a register), parity bit (if enabled), then the first stop bit.

RX frame completion:
- The cycle after the stop-bit sample: rx_valid=1 for one cycle.
- On that same edge rx_data, rx_parity_err and rx_frame_err are loaded.
- Errors do not suppress rx_valid or rx_data.
- The FSM then returns to IDLE and may detect a new start edge from the next cycle.
- The second stop bit is not checked.
- A line held low after a frame error is not taken as a new start until a high-to-low edge is seen.

Independence:
- TX and RX share nothing except loopback.
- Simultaneous TX and RX activity is fully independent.

Test Plan:
1. Reset/idle: rst=0 then 1, no stimulus for 100 cycles -> txd=1; tx_busy, tx_done, rx_valid and both error flags stay 0.
2. TX framing (DATA_BITS=8, CLKS_PER_BIT=4, even parity, 1 stop): pulse tx_start with tx_data=8'hC1.
   - txd sequence, 4 cycles each: 0 | 1,0,0,0,0,0,1,1 | 1 | 1.
   - tx_busy high for 44 cycles; tx_done pulses exactly once, 44 cycles after acceptance.
   - A second tx_start at cycle 10 is ignored.
3. Loopback: loopback=1, send 8'h81 then immediately 8'h3C back-to-back.
   - Two rx_valid pulses with rx_data=8'h81 then 8'h3C; both error flags 0.
   - The pin txd stays 1 throughout.
4. Parity error: drive rxd with the frame for 8'h81 but parity bit=1 (correct value is 0) -> rx_valid pulse, rx_data=8'h81, rx_parity_err=1, rx_frame_err=0.
5. Frame error and false start:
   - Drive a frame for 8'h55 with stop bit=0 -> rx_valid, rx_frame_err=1.
   - Then a 1-cycle low glitch on an idle line -> no rx_valid, flags unchanged.
6. Reset mid-operation: assert rst during the DATA bits of both a TX and an RX frame.
   - txd=1 and tx_busy=0 immediately; no rx_valid.
   - A clean frame 8'hA5 afterwards is sent and received correctly.
